oled_frame_compositor: RTL
==========================

OLED_FRAME_COMPOSITOR -- requirements
Module: oled_frame_compositor

Interface
REQ-001 SHALL have parameter WIDTH, default 96: display columns.
REQ-002 SHALL have parameter HEIGHT, default 64: display rows.
REQ-003 SHALL have parameter NUM_LAYERS, default 4: number of pixel source layers, range 1..8.
REQ-004 SHALL have parameter COLOR_W, default 16: pixel colour width (RGB565).
REQ-005 SHALL have parameter KEY_COLOR, default 16'hF81F: transparent colour key.
REQ-006 SHALL have parameter CURSOR_SHIFT, default 0: right-shift applied to mouse coordinates.
REQ-007 SHALL have ports: clock in 1, system clock; reset_n in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: frame_begin in 1, start of OLED frame; sample_pixel in 1, OLED consumed current pixel.
REQ-009 SHALL have ports: pixel_x out 7, pixel_y out 7, coordinate of the pixel being composed.
REQ-010 SHALL have ports: layer_data in NUM_LAYERS*COLOR_W, layer i at bits [i*COLOR_W +: COLOR_W]; layer_en in NUM_LAYERS.
REQ-011 SHALL have ports: bg_color in COLOR_W; pixel_data out COLOR_W, composed colour.
REQ-012 SHALL have ports: mouse_x in 12, mouse_y in 12, mouse_left in 1.
REQ-013 SHALL have ports: cursor_x out 7, cursor_y out 7, click_pulse out 1, click_x out 7, click_y out 7, frame_count out 8.

Function
REQ-014 SHALL hold x/y counters; sample_pixel increments x; at x==WIDTH-1 x wraps to 0 and y increments; at (WIDTH-1,HEIGHT-1) both wrap to 0.
REQ-015 SHALL set x=y=0 on frame_begin; frame_begin and sample_pixel in the same cycle: frame_begin wins.
REQ-016 SHALL drive pixel_x/pixel_y directly from the counters (no division/modulo).
REQ-017 SHALL register pixel_data one clock after pixel_x/pixel_y change; sample_pixel pulses are spaced at least 2 clocks apart.
REQ-018 SHALL select the lowest index i with layer_en[i]=1 and layer colour != KEY_COLOR; if none, bg_color.
REQ-019 SHALL latch cursor_x = min(mouse_x>>CURSOR_SHIFT, WIDTH-1) and cursor_y = min(mouse_y>>CURSOR_SHIFT, HEIGHT-1) on frame_begin only (no tearing).
REQ-020 SHALL increment frame_count (mod 256) on each frame_begin.
REQ-021 SHALL register mouse_left and emit click_pulse for exactly one clock on its rising edge, with click_x/click_y loaded from the latched cursor in the same cycle and held until the next click.
REQ-022 SHALL ignore a held mouse_left: no further pulse until released and re-pressed.

Reset
REQ-023 SHALL on reset_n=0 clear counters, pixel_data, cursor_x/y, click_x/y, click_pulse, frame_count and the mouse_left history to 0, immediately and asynchronously.
REQ-024 SHALL after reset mid-frame compose from (0,0) and await the next frame_begin before latching the cursor.

Configuration
REQ-025 SHALL with CURSOR_OVERLAY_EN defined draw a 3x3 white (all-ones) square whose top-left is (cursor_x,cursor_y), clipped at the display edge, above all layers.
REQ-026 SHALL without CURSOR_OVERLAY_EN draw no cursor; cursor latching and click outputs remain functional.

Structure
REQ-027 SHALL place OLED_WIDTH, OLED_HEIGHT, KEY_COLOR default, COLOR_WHITE and the coordinate width in shared package oled_pkg.
REQ-028 SHALL implement priority selection in sub-module layer_priority_mux (combinational, parametrised by NUM_LAYERS, COLOR_W); counters, latching and click logic stay in the top module.

Verification
REQ-029 SHALL test: frame_begin then 96 sample_pixel -> pixel_x returns to 0, pixel_y=1; after 6144 samples -> (0,0).
REQ-030 SHALL test: layer_en=4'b0011, layer0=KEY_COLOR, layer1=16'h07E0 -> pixel_data=16'h07E0; layer_en=0 -> bg_color.
REQ-031 SHALL test: mouse_x=200, mouse_y=10, CURSOR_SHIFT=0, frame_begin -> cursor=(95,10); change mouse_x to 5 mid-frame -> cursor unchanged until next frame_begin.
REQ-032 SHALL test: mouse_left 0->1 held 100 clocks -> exactly one click_pulse, click_x/y equal latched cursor.
REQ-033 SHALL test: CURSOR_OVERLAY_EN, cursor=(94,63), pixels (95,63) -> 16'hFFFF; pixel (0,0) -> layer colour, no wrap.
REQ-034 SHALL test: reset_n low at pixel (40,20) -> all outputs 0 within the same cycle; frame_count restarts at 0.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared display geometry, colour constants and coordinate width for the OLED frame compositor.
package oled_pkg;
    localparam int OLED_WIDTH  = 96;
    localparam int OLED_HEIGHT = 64;
    localparam int COORD_W     = 7;
    localparam logic [15:0] KEY_COLOR_DEFAULT = 16'hF81F;
    localparam logic [15:0] COLOR_WHITE       = 16'hFFFF;
endpackage

// File: rtl/layer_priority_mux.sv
// Combinational layer selector: lowest-index enabled layer whose colour is not the key wins, else background.
module layer_priority_mux #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 16,
    parameter logic [COLOR_W-1:0] KEY_COLOR = '1
) (
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_data,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [COLOR_W-1:0]            bg_color,
    output logic [COLOR_W-1:0]            color
);
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves color unassigned (that would infer a latch).
        color = bg_color;
        // Walk from the highest index down so the lowest opaque layer is the last writer.
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_en[i] && (layer_data[i*COLOR_W +: COLOR_W] != KEY_COLOR))
                color = layer_data[i*COLOR_W +: COLOR_W];
        end
    end
endmodule

// File: rtl/oled_frame_compositor.sv
// OLED frame compositor: pixel scan counters, layer composition, cursor latch and click capture.
// Optional CURSOR_OVERLAY_EN draws a 3x3 white cursor above all layers.
module oled_frame_compositor
    import oled_pkg::*;
#(
    parameter int WIDTH        = OLED_WIDTH,
    parameter int HEIGHT       = OLED_HEIGHT,
    parameter int NUM_LAYERS   = 4,
    parameter int COLOR_W      = 16,
    parameter logic [COLOR_W-1:0] KEY_COLOR = COLOR_W'(KEY_COLOR_DEFAULT),
    parameter int CURSOR_SHIFT = 0
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          frame_begin,
    input  logic                          sample_pixel,
    output logic [COORD_W-1:0]            pixel_x,
    output logic [COORD_W-1:0]            pixel_y,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_data,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [COLOR_W-1:0]            bg_color,
    output logic [COLOR_W-1:0]            pixel_data,
    input  logic [11:0]                   mouse_x,
    input  logic [11:0]                   mouse_y,
    input  logic                          mouse_left,
    output logic [COORD_W-1:0]            cursor_x,
    output logic [COORD_W-1:0]            cursor_y,
    output logic                          click_pulse,
    output logic [COORD_W-1:0]            click_x,
    output logic [COORD_W-1:0]            click_y,
    output logic [7:0]                    frame_count
);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);
    localparam logic [11:0]        X_CLAMP = 12'(WIDTH - 1);
    localparam logic [11:0]        Y_CLAMP = 12'(HEIGHT - 1);

    logic [COORD_W-1:0] x_cnt, y_cnt;
    logic [COLOR_W-1:0] layer_color, next_pixel;
    logic [11:0]        mouse_x_scaled, mouse_y_scaled;
    logic               mouse_left_q;

    assign pixel_x = x_cnt;
    assign pixel_y = y_cnt;
    assign mouse_x_scaled = mouse_x >> CURSOR_SHIFT;
    assign mouse_y_scaled = mouse_y >> CURSOR_SHIFT;

    layer_priority_mux #(
        .NUM_LAYERS (NUM_LAYERS),
        .COLOR_W    (COLOR_W),
        .KEY_COLOR  (KEY_COLOR)
    ) u_mux (
        .layer_data (layer_data),
        .layer_en   (layer_en),
        .bg_color   (bg_color),
        .color      (layer_color)
    );

`ifdef CURSOR_OVERLAY_EN
    logic in_cursor;
    // The >= guard keeps the subtraction from wrapping, so the square clips at the edge instead of wrapping to column 0.
    assign in_cursor = (x_cnt >= cursor_x) && ((x_cnt - cursor_x) < COORD_W'(3)) &&
                       (y_cnt >= cursor_y) && ((y_cnt - cursor_y) < COORD_W'(3));
    assign next_pixel = in_cursor ? '1 : layer_color;
`else
    assign next_pixel = layer_color;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (frame_begin) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (sample_pixel) begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pixel_data <= '0;
        else          pixel_data <= next_pixel;
    end

    // Cursor only moves at frame boundaries so a frame never shows a torn cursor.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cursor_x    <= '0;
            cursor_y    <= '0;
            frame_count <= '0;
        end else if (frame_begin) begin
            cursor_x    <= COORD_W'((mouse_x_scaled > X_CLAMP) ? X_CLAMP : mouse_x_scaled);
            cursor_y    <= COORD_W'((mouse_y_scaled > Y_CLAMP) ? Y_CLAMP : mouse_y_scaled);
            frame_count <= frame_count + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mouse_left_q <= 1'b0;
            click_pulse  <= 1'b0;
            click_x      <= '0;
            click_y      <= '0;
        end else begin
            mouse_left_q <= mouse_left;
            click_pulse  <= mouse_left && !mouse_left_q;
            if (mouse_left && !mouse_left_q) begin
                click_x <= cursor_x;
                click_y <= cursor_y;
            end
        end
    end
endmodule
